// File: rtl/data_sym_deint_pkg.sv
// Shared constants, dibit type and 802.11a first-permutation address map for data_sym_deint.
package data_sym_deint_pkg;

   localparam int NCBPS_DFLT = 96;
   localparam int W_DFLT     = NCBPS_DFLT / 2;
   localparam int NCOL_DFLT  = NCBPS_DFLT / 16;

   typedef struct packed {
      logic q;
      logic i;
   } dibit_t;

   // Received bit j lands at transmit-order address k.
   function automatic int deint_addr(input int j, input int ncol);
      return 16 * (j % ncol) + j / ncol;
   endfunction

endpackage

// File: rtl/deint_bank.sv
// One NCBPS-bit symbol store: two-bit scatter write, sequential two-bit word read.
module deint_bank
   import data_sym_deint_pkg::*;
#(
   parameter  int NCBPS = NCBPS_DFLT,
   localparam int AW    = $clog2(NCBPS),
   localparam int CW    = $clog2(NCBPS / 2)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_we,
   input  logic          i_clr,
   input  logic [AW-1:0] i_waddr0,
   input  logic [AW-1:0] i_waddr1,
   input  dibit_t        i_wdat,
   input  logic [CW-1:0] i_ridx,
   output dibit_t        o_rdat
);

   logic [NCBPS-1:0] r_mem;

   // Clearing on free is what makes a flushed partial symbol read back zero-filled.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mem <= '0;
      end else if (i_clr) begin
         r_mem <= '0;
      end else if (i_we) begin
         r_mem[i_waddr0] <= i_wdat.i;
         r_mem[i_waddr1] <= i_wdat.q;
      end
   end

   assign o_rdat.i = r_mem[{i_ridx, 1'b0}];
   assign o_rdat.q = r_mem[{i_ridx, 1'b1}];

endmodule

// File: rtl/data_sym_deint.sv
// QPSK data-symbol deinterleaver with ping-pong banks, one dibit per word in and out.
// Build option DEINT_FLUSH_EN: zero-fill and emit a partial symbol when CYC_I falls.
module data_sym_deint
   import data_sym_deint_pkg::*;
#(
   parameter int NCBPS = NCBPS_DFLT
) (
   input  logic       CLK_I,
   input  logic       RST_I,
   input  logic [7:0] DAT_I,
   input  logic       WE_I,
   input  logic       STB_I,
   input  logic       CYC_I,
   output logic       ACK_O,
   output logic [7:0] DAT_O,
   output logic       CYC_O,
   output logic       STB_O,
   output logic       WE_O,
   input  logic       ACK_I
);

   localparam int W    = NCBPS / 2;
   localparam int NCOL = NCBPS / 16;
   localparam int AW   = $clog2(NCBPS);
   localparam int CW   = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   logic          r_wbank, r_rbank, r_stb, r_cyc;
   logic [CW-1:0] r_wcnt, r_rcnt;
   logic [1:0]    r_full;
   logic [1:0]    r_dat;

   logic          w_acc, w_wlast, w_part, w_flush, w_discard;
   logic          w_halt, w_rd, w_free, w_cyc_nxt, w_unused;
   logic [1:0]    w_full_nxt;
   logic [AW-1:0] w_waddr0, w_waddr1;
   dibit_t        w_wdat, w_rdat;
   dibit_t        w_rdat_b [2];

   assign w_acc   = CYC_I & STB_I & WE_I & ~r_full[r_wbank];
   assign w_wlast = w_acc & (r_wcnt == LAST);
   assign w_part  = ~CYC_I & (r_wcnt != '0);
`ifdef DEINT_FLUSH_EN
   assign w_flush   = w_part;
   assign w_discard = 1'b0;
`else
   assign w_flush   = 1'b0;
   assign w_discard = w_part;
`endif

   assign w_halt = r_stb & ~ACK_I;
   assign w_rd   = ~w_halt & r_full[r_rbank];
   assign w_free = w_rd & (r_rcnt == LAST);

   assign w_waddr0 = AW'(deint_addr(2 * int'(r_wcnt), NCOL));
   assign w_waddr1 = AW'(deint_addr(2 * int'(r_wcnt) + 1, NCOL));
   assign w_wdat   = dibit_t'(DAT_I[1:0]);
   assign w_unused = ^DAT_I[7:2];

   for (genvar b = 0; b < 2; b++) begin : g_bank
      deint_bank #(.NCBPS(NCBPS)) u_bank (
         .i_clk    (CLK_I),
         .i_rst    (RST_I),
         .i_we     (w_acc & (r_wbank == 1'(b))),
         .i_clr    ((w_free & (r_rbank == 1'(b))) | (w_discard & (r_wbank == 1'(b)))),
         .i_waddr0 (w_waddr0),
         .i_waddr1 (w_waddr1),
         .i_wdat   (w_wdat),
         .i_ridx   (r_rcnt),
         .o_rdat   (w_rdat_b[b])
      );
   end
   assign w_rdat = w_rdat_b[r_rbank];

   // Fill and free always target different banks, so both may land in one cycle.
   always_comb begin
      w_full_nxt = r_full;
      if (w_wlast | w_flush) w_full_nxt[r_wbank] = 1'b1;
      if (w_free)            w_full_nxt[r_rbank] = 1'b0;
   end

   always_comb begin
      w_cyc_nxt = r_cyc;
      if (w_rd & CYC_I)
         w_cyc_nxt = 1'b1;
      else if (~CYC_I & ~r_stb & (r_full == 2'b00))
         w_cyc_nxt = 1'b0;
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         r_full  <= '0;
         r_wbank <= 1'b0;
         r_rbank <= 1'b0;
         r_wcnt  <= '0;
         r_rcnt  <= '0;
         r_stb   <= 1'b0;
         r_dat   <= '0;
         r_cyc   <= 1'b0;
      end else begin
         r_full <= w_full_nxt;
         r_cyc  <= w_cyc_nxt;
         if (w_wlast | w_flush) begin
            r_wcnt  <= '0;
            r_wbank <= ~r_wbank;
         end else if (w_discard) begin
            r_wcnt <= '0;
         end else if (w_acc) begin
            r_wcnt <= r_wcnt + 1'b1;
         end
         if (~w_halt) begin
            r_stb <= w_rd;
            if (w_rd) begin
               r_dat <= w_rdat;
               if (w_free) begin
                  r_rcnt  <= '0;
                  r_rbank <= ~r_rbank;
               end else begin
                  r_rcnt <= r_rcnt + 1'b1;
               end
            end
         end
      end
   end

   assign ACK_O = w_acc;
   assign DAT_O = {6'd0, r_dat};
   assign STB_O = r_stb;
   assign WE_O  = r_stb;
   assign CYC_O = r_cyc;

endmodule

// File: tb/tb_data_sym_deint.sv
// Directed bench for data_sym_deint at NCBPS = 96 (W = 48, 6 columns).
module tb_data_sym_deint;

   localparam int W = 48;

   logic       CLK_I = 1'b0;
   logic       RST_I;
   logic [7:0] DAT_I;
   logic       WE_I, STB_I, CYC_I, ACK_I;
   logic       ACK_O, CYC_O, STB_O, WE_O;
   logic [7:0] DAT_O;

   data_sym_deint #(.NCBPS(96)) dut (
      .CLK_I (CLK_I),
      .RST_I (RST_I),
      .DAT_I (DAT_I),
      .WE_I  (WE_I),
      .STB_I (STB_I),
      .CYC_I (CYC_I),
      .ACK_O (ACK_O),
      .DAT_O (DAT_O),
      .CYC_O (CYC_O),
      .STB_O (STB_O),
      .WE_O  (WE_O),
      .ACK_I (ACK_I)
   );

   always #5 CLK_I = ~CLK_I;

   int n_chk = 0;
   int n_err = 0;
   int cyc_n = 0;

   logic [7:0] out_q[$];
   int         out_cyc[$];
   int         acc_cyc[$];

   logic [1:0] in_sym [3][W];
   logic [7:0] exp_out [3*W];

   typedef struct {
      int         in_word;
      logic [1:0] in_dat;
      int         out_word;
      logic [7:0] out_exp;
   } vec_t;
   vec_t vecs [7];

   always @(posedge CLK_I) cyc_n <= cyc_n + 1;

   always @(negedge CLK_I) begin
      if (!RST_I) begin
         if (STB_O && ACK_I) begin
            out_q.push_back(DAT_O);
            out_cyc.push_back(cyc_n);
         end
         if (ACK_O) acc_cyc.push_back(cyc_n);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout want finish");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic clear_q();
      out_q.delete();
      out_cyc.delete();
      acc_cyc.delete();
   endtask

   task automatic idle();
      STB_I = 1'b0;
      WE_I  = 1'b0;
   endtask

   task automatic send_word(input logic [1:0] d);
      bit acc;
      acc   = 1'b0;
      CYC_I = 1'b1;
      STB_I = 1'b1;
      WE_I  = 1'b1;
      DAT_I = {6'b101101, d};
      for (int t = 0; t < 1000 && !acc; t++) begin
         @(negedge CLK_I);
         acc = ACK_O;
         @(posedge CLK_I);
         #1;
      end
      if (!acc) check("send_timeout", 0, 1);
   endtask

   task automatic send_sym(input int s, input int nw);
      for (int n = 0; n < nw; n++) send_word(in_sym[s][n]);
   endtask

   task automatic rand_sym(input int s);
      for (int n = 0; n < W; n++) in_sym[s][n] = 2'($urandom_range(0, 3));
   endtask

   // Reference: row-major write of 16 rows x 6 columns, column-major read.
   task automatic build_exp(input int nsym);
      for (int i = 0; i < 3*W; i++) exp_out[i] = 8'h00;
      for (int s = 0; s < nsym; s++)
         for (int r = 0; r < 16; r++)
            for (int c = 0; c < 6; c++) begin
               int j, k;
               j = 6*r + c;
               k = 16*c + r;
               exp_out[s*W + k/2][k%2] = in_sym[s][j/2][j%2];
            end
   endtask

   task automatic wait_out(input int n, input int budget);
      for (int i = 0; i < budget && out_q.size() < n; i++) @(posedge CLK_I);
      repeat (4) @(posedge CLK_I);
      #1;
   endtask

   task automatic compare_out(input string name, input int n);
      int e;
      e = 0;
      for (int i = 0; i < n; i++)
         if (i >= out_q.size() || out_q[i] !== exp_out[i]) e++;
      check({name, "_count"}, out_q.size(), n);
      check({name, "_data_errs"}, e, 0);
   endtask

   initial begin
      vecs[0] = '{0,  2'b10, 8,  8'h01};
      vecs[1] = '{3,  2'b01, 0,  8'h02};
      vecs[2] = '{0,  2'b01, 0,  8'h01};
      vecs[3] = '{47, 2'b10, 47, 8'h02};
      vecs[4] = '{47, 2'b01, 39, 8'h02};
      vecs[5] = '{5,  2'b10, 40, 8'h02};
      vecs[6] = '{20, 2'b01, 35, 8'h01};

      // Reset with ena held high
      RST_I = 1'b1; CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; DAT_I = 8'h03; ACK_I = 1'b1;
      repeat (3) @(posedge CLK_I);
      @(negedge CLK_I);
      check("rst_dat_o", DAT_O, 0);
      check("rst_stb_o", STB_O, 0);
      check("rst_cyc_o", CYC_O, 0);
      check("rst_we_o", WE_O, 0);
      check("rst_ack_o", ACK_O, 1);
      idle();
      @(posedge CLK_I); #1;
      RST_I = 1'b0;
      @(posedge CLK_I); #1;

      // Single-bit symbols from the vector table
      foreach (vecs[v]) begin
         int act, nz;
         clear_q();
         for (int n = 0; n < W; n++) in_sym[0][n] = 2'b00;
         in_sym[0][vecs[v].in_word] = vecs[v].in_dat;
         send_sym(0, W);
         idle();
         wait_out(W, 300);
         check($sformatf("vec%0d_count", v), out_q.size(), W);
         act = (out_q.size() > vecs[v].out_word) ? int'(out_q[vecs[v].out_word]) : -1;
         check($sformatf("vec%0d_word%0d", v, vecs[v].out_word), act, int'(vecs[v].out_exp));
         nz = 0;
         for (int i = 0; i < out_q.size(); i++)
            if (i != vecs[v].out_word && out_q[i] != 8'h00) nz++;
         check($sformatf("vec%0d_other_nonzero", v), nz, 0);
      end
      check("cyc_o_set", CYC_O, 1);

      // Three back-to-back random symbols at full rate
      clear_q();
      for (int s = 0; s < 3; s++) rand_sym(s);
      build_exp(3);
      for (int s = 0; s < 3; s++) send_sym(s, W);
      idle();
      wait_out(3*W, 400);
      compare_out("b2b", 3*W);
      if (acc_cyc.size() >= 3*W && out_q.size() >= 3*W) begin
         int gaps;
         check("b2b_ack_span", acc_cyc[3*W-1] - acc_cyc[0], 3*W - 1);
         check("b2b_latency", out_cyc[0] - acc_cyc[W-1], 2);
         gaps = 0;
         for (int i = 0; i < 3*W - 1; i++)
            if (out_cyc[i+1] - out_cyc[i] != 1) gaps++;
         check("b2b_out_gaps", gaps, 0);
      end else begin
         check("b2b_queue_depth", acc_cyc.size(), 3*W);
      end

      // Downstream stall for 200 cycles
      clear_q();
      for (int s = 0; s < 3; s++) rand_sym(s);
      build_exp(3);
      ACK_I = 1'b0;
      fork
         begin
            for (int s = 0; s < 3; s++) send_sym(s, W);
            idle();
         end
         begin
            repeat (50) @(posedge CLK_I);
            @(negedge CLK_I);
            check("halt_dat_early", DAT_O, exp_out[0]);
            repeat (150) @(posedge CLK_I);
            @(negedge CLK_I);
            check("halt_accepts", acc_cyc.size(), 2*W);
            check("halt_ack_o", ACK_O, 0);
            check("halt_stb_o", STB_O, 1);
            check("halt_dat_late", DAT_O, exp_out[0]);
            @(posedge CLK_I); #1;
            ACK_I = 1'b1;
         end
      join
      wait_out(3*W, 500);
      compare_out("halt", 3*W);

      // CYC_I falls after 10 words of a symbol
      CYC_I = 1'b0;
      idle();
      repeat (5) @(posedge CLK_I);
      @(negedge CLK_I);
      check("cyc_o_cleared", CYC_O, 0);
      @(posedge CLK_I); #1;
      clear_q();
      rand_sym(0);
      for (int n = 10; n < W; n++) in_sym[0][n] = 2'b00;
      build_exp(1);
      send_sym(0, 10);
      idle();
      CYC_I = 1'b0;
      repeat (120) @(posedge CLK_I);
      #1;
`ifdef DEINT_FLUSH_EN
      compare_out("flush", W);
`else
      check("drop_count", out_q.size(), 0);
`endif
      check("drop_cyc_o", CYC_O, 0);
      clear_q();
      rand_sym(0);
      build_exp(1);
      send_sym(0, W);
      idle();
      wait_out(W, 300);
      compare_out("after_drop", W);

      // Reset while symbol 1 drains and symbol 2 is partly written
      clear_q();
      rand_sym(0);
      rand_sym(1);
      send_sym(0, W);
      send_sym(1, 30);
      idle();
      @(negedge CLK_I);
      check("pre_rst_stb_o", STB_O, 1);
      #1;
      RST_I = 1'b1;
      #2;
      check("mid_rst_stb_o", STB_O, 0);
      check("mid_rst_dat_o", DAT_O, 0);
      check("mid_rst_cyc_o", CYC_O, 0);
      @(posedge CLK_I); #1;
      RST_I = 1'b0;
      @(posedge CLK_I); #1;
      clear_q();
      rand_sym(0);
      build_exp(1);
      send_sym(0, W);
      idle();
      wait_out(W, 300);
      compare_out("post_rst", W);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/data_sym_deint.md
# data_sym_deint

QPSK data-symbol deinterleaver for the 802.11a receive chain, sitting directly downstream of the QPSK demapper and upstream of the Viterbi decoder front end. It accepts one demapped dibit per word over the codebase's Wishbone-style stream handshake, collects one OFDM symbol of coded bits (NCBPS) and reorders them with the inverse 802.11a first permutation. Output is in transmit coded-bit order, two bits per word. Ping-pong buffering sustains one word per cycle on both sides.

## Interface
- NCBPS, 96: coded bits per OFDM symbol; legal values are multiples of 16 in 32..192; words per symbol W = NCBPS/2
- CLK_I  in  1  clock
- RST_I  in  1  reset, asynchronous, active-high
- DAT_I  in  8  [1] = received bit 2n+1 (Q), [0] = received bit 2n (I); [7:2] ignored
- WE_I, STB_I, CYC_I  in  1 each  upstream write strobe, data strobe, cycle
- ACK_O  out  1  word accepted this cycle
- DAT_O  out  8  {6'd0, bit 2m+1, bit 2m} of deinterleaved symbol
- CYC_O, STB_O  out  1 each  output cycle / data valid (registered)
- WE_O  out  1  equals STB_O
- ACK_I  in  1  downstream accept

## Operation
- ena = CYC_I & STB_I & WE_I; ACK_O = ena & write bank not full; word accepted when ACK_O = 1.
- Received bit j of the current symbol is written to bank address k = 16*(j mod (NCBPS/16)) + floor(j/(NCBPS/16)); both bits of a word are written in one cycle.
- Two banks of NCBPS bits. The write pointer fills one bank; after word W-1 is accepted, that bank is marked full and the write pointer moves to the other bank and clears its word counter.
- Read side drains the full bank sequentially: output word m carries addresses 2m (DAT_O[0]) and 2m+1 (DAT_O[1]), m = 0..W-1; bank is freed after word W-1 is taken.
- out_halt = STB_O & ~ACK_I; DAT_O/STB_O/read counter update only when ~out_halt.
- Banks fill and drain alternately, strictly in order; at most two symbols are buffered.
- CYC_O: set when the first output word is presented while CYC_I = 1; cleared when CYC_I = 0, STB_O = 0 and both banks are empty.
- Partial symbol at a CYC_I fall: see Configuration.

## Timing
- Reset values: DAT_O = 0, STB_O = 0, CYC_O = 0, WE_O = 0, both banks empty, counters 0; ACK_O is combinational and equals ena after reset.
- Latency: if the last word of a symbol is accepted at edge t, STB_O = 1 with output word 0 after edge t+1.
- Throughput: 1 word/cycle in and out with ACK_I held high; ACK_O never drops in this mode.
- Both banks full: ACK_O = 0 until the draining bank frees; ACK_O returns in the cycle after word W-1 is taken.
- A simultaneous bank free and bank fill in the same cycle are both honoured.
- Reset mid-operation: partial and full banks are discarded, and all outputs return to their reset values immediately.

## Configuration
- DEINT_FLUSH_EN defined: when CYC_I falls with 0 < count < W words in the write bank, the remaining bits are zero-filled, the bank is marked full and drained normally (W words out).
- Undefined: the partial symbol is discarded (the counter clears, and no output is produced).

## Structure
- Shared package/header: the NCBPS default, W, NCBPS/16 column count, and the deinterleave address function.
- One sub-module, deint_bank: NCBPS-bit storage with dual-bit scatter write and sequential dual-bit read; instantiated twice.

## Test plan
- Reset with ena = 1 -> DAT_O = 0, STB_O = 0, CYC_O = 0, ACK_O = 1.
- One symbol, NCBPS = 96: word 0 = 8'h02 (j = 1), others 0 -> exactly 48 output words, word 8 = 8'h01 (k = 16), others 0. Word 3 = 8'h01 (j = 6) alone -> output word 0 = 8'h02 (k = 1).
- Three back-to-back random symbols, ACK_I = 1 -> ACK_O constantly high, 144 contiguous output words matching the reference model, first output one cycle after the 48th accept.
- ACK_I = 0 for 200 cycles -> exactly 96 words accepted, then ACK_O = 0; STB_O = 1 and DAT_O held stable; release -> all 3 symbols out with no loss or duplication.
- CYC_I drops after 10 words -> with DEINT_FLUSH_EN, 48 words out (zero-filled), then CYC_O = 0; without it, no output and CYC_O stays 0.
- RST_I pulsed after 30 words of symbol 2 while symbol 1 drains -> outputs reset at once; the next full symbol is deinterleaved correctly.
